// File: rtl/axi_rd_arbiter_pkg.sv
// Shared definitions for the two-master AXI-lite read arbiter.
package axi_rd_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_AR   = 2'd1,
    ARB_R    = 2'd2
  } arb_state_e;

  localparam logic GNT_IFU = 1'b0;
  localparam logic GNT_LSU = 1'b1;

endpackage

// File: rtl/axi_rd_arbiter_mux2.sv
// Parameterised 2:1 select used for the AR payload and the R ready path.
module axi_rd_arbiter_mux2 #(
  parameter int WIDTH = 1
) (
  input  logic             i_sel,
  input  logic [WIDTH-1:0] i_d0,
  input  logic [WIDTH-1:0] i_d1,
  output logic [WIDTH-1:0] o_y
);

  assign o_y = i_sel ? i_d1 : i_d0;

endmodule

// File: rtl/axi_rd_arbiter.sv
// Two-master AXI-lite read arbiter: one outstanding read, grant locked from AR to R, LSU has priority.
//   state    | meaning
//   ARB_IDLE | no grant, nothing driven to the slave
//   ARB_AR   | granted master's address forwarded, waiting for AR handshake
//   ARB_R    | waiting for the R handshake of the granted master
module axi_rd_arbiter
  import axi_rd_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,

  input  logic [ADDR_WIDTH-1:0] ifu_araddr_i,
  input  logic                  ifu_arvalid_i,
  output logic                  ifu_arready_o,
  output logic [DATA_WIDTH-1:0] ifu_rdata_o,
  output logic [1:0]            ifu_rresp_o,
  output logic                  ifu_rvalid_o,
  input  logic                  ifu_rready_i,

  input  logic [ADDR_WIDTH-1:0] lsu_araddr_i,
  input  logic                  lsu_arvalid_i,
  output logic                  lsu_arready_o,
  output logic [DATA_WIDTH-1:0] lsu_rdata_o,
  output logic [1:0]            lsu_rresp_o,
  output logic                  lsu_rvalid_o,
  input  logic                  lsu_rready_i,

  output logic [ADDR_WIDTH-1:0] araddr_o,
  output logic                  arvalid_o,
  input  logic                  arready_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  input  logic [1:0]            rresp_i,
  input  logic                  rvalid_i,
  output logic                  rready_o
);

  arb_state_e r_state;
  logic       r_gnt;

  logic                  w_in_ar;
  logic                  w_in_r;
  logic                  w_gnt_lsu;
  logic [ADDR_WIDTH:0]   w_ar_sel;
  logic                  w_rready_sel;
  logic                  w_ar_hs;
  logic                  w_r_hs;

  axi_rd_arbiter_mux2 #(.WIDTH(ADDR_WIDTH + 1)) u_ar_mux (
    .i_sel (r_gnt),
    .i_d0  ({ifu_araddr_i, ifu_arvalid_i}),
    .i_d1  ({lsu_araddr_i, lsu_arvalid_i}),
    .o_y   (w_ar_sel)
  );

  axi_rd_arbiter_mux2 #(.WIDTH(1)) u_rready_mux (
    .i_sel (r_gnt),
    .i_d0  (ifu_rready_i),
    .i_d1  (lsu_rready_i),
    .o_y   (w_rready_sel)
  );

  assign w_in_ar   = (r_state == ARB_AR);
  assign w_in_r    = (r_state == ARB_R);
  assign w_gnt_lsu = (r_gnt == GNT_LSU);

  // Address is forced to zero outside AR so the slave sees nothing while idle.
  assign araddr_o  = w_in_ar ? w_ar_sel[ADDR_WIDTH:1] : '0;
  assign arvalid_o = w_in_ar & w_ar_sel[0];
  assign rready_o  = w_in_r & w_rready_sel;

  assign ifu_arready_o = w_in_ar & ~w_gnt_lsu & arready_i;
  assign lsu_arready_o = w_in_ar &  w_gnt_lsu & arready_i;
  assign ifu_rvalid_o  = w_in_r  & ~w_gnt_lsu & rvalid_i;
  assign lsu_rvalid_o  = w_in_r  &  w_gnt_lsu & rvalid_i;

  // Only rvalid is gated; payload goes to both masters unchanged.
  assign ifu_rdata_o = rdata_i;
  assign ifu_rresp_o = rresp_i;
  assign lsu_rdata_o = rdata_i;
  assign lsu_rresp_o = rresp_i;

  assign w_ar_hs = arvalid_o & arready_i;
  assign w_r_hs  = rvalid_i & rready_o;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ARB_IDLE;
      r_gnt   <= GNT_IFU;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (lsu_arvalid_i) begin
            r_gnt   <= GNT_LSU;
            r_state <= ARB_AR;
          end else if (ifu_arvalid_i) begin
            r_gnt   <= GNT_IFU;
            r_state <= ARB_AR;
          end
        end
        ARB_AR: begin
          if (w_ar_hs) r_state <= ARB_R;
        end
        ARB_R: begin
          if (w_r_hs) r_state <= ARB_IDLE;
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

endmodule
